branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Execute-stage branch sequencer that drives the signed/unsigned select of the shared branch comparator and turns its eq/lt flags into a taken decision per RV32I funct3.
- Checks each decision against the fetch-time prediction from an internal bimodal table of 2-bit counters, then issues a registered PC redirect and a multi-cycle front-end flush on mispredict or jump.
- Trains the prediction table and keeps branch and mispredict performance counters.

Parameters:
- BHT_IDX_W, 6, log2 of prediction table entries; index = pc[BHT_IDX_W+1:2].
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect; legal range 1..7.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  fetch PC for prediction lookup.
- if_pred_taken  out  1  combinational prediction for if_pc (counter MSB).
- ex_valid  in  1  EX-stage instruction valid.
- ex_is_branch  in  1  conditional branch in EX.
- ex_is_jal  in  1  JAL in EX.
- ex_is_jalr  in  1  JALR in EX.
- ex_funct3  in  3  branch funct3.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended B/J immediate.
- ex_jalr_target  in  32  rs1+imm from the ALU.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- br_un  out  1  comparator unsigned select.
- br_eq  in  1  comparator equal flag.
- br_lt  in  1  comparator less-than flag.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  32  redirect target.
- flush  out  1  squash IF/ID and ID/EX.
- illegal_br  out  1  one-cycle pulse for funct3 010/011.
- branch_cnt  out  32  resolved conditional branches.
- mispred_cnt  out  32  mispredicted conditional branches.

Behaviour:
- br_un = ex_funct3[1], driven combinationally regardless of valid.
- Taken decode:
  - 000 = eq, 001 = !eq.
  - 100 and 110 = lt, 101 and 111 = !lt.
  - 010 and 011 = not taken, with illegal_br pulsed the next cycle.
- Resolve event at cycle T = ex_valid & !flush & (ex_is_branch | ex_is_jal | ex_is_jalr). If more than one type flag is set, priority is jalr > jal > branch.
- Mispredict (branch only) = taken != ex_pred_taken.
  - taken gives target ex_pc+ex_imm.
  - not taken gives target ex_pc+4.
  - Additions are 32-bit and wrap modulo 2^32.
- JAL always redirects to ex_pc+ex_imm. JALR always redirects to ex_jalr_target with bit0 cleared.
- Redirect is registered. At T+1: redirect_valid=1 and redirect_pc=target, for exactly one cycle.
- FSM:
  - IDLE: a redirecting resolve moves to FLUSH with cnt=FLUSH_CYCLES-1.
  - FLUSH: flush=1; decrement cnt each cycle; return to IDLE when cnt==0 that cycle.
  - flush is high T+1..T+FLUSH_CYCLES inclusive. All EX inputs are ignored while flush=1: no resolve, no training, no count.
- BHT:
  - 2^BHT_IDX_W entries of 2-bit saturating counters.
  - On each conditional-branch resolve, the entry at ex_pc index moves +1 if taken and -1 if not, saturating at 3 and 0. Written at the clock edge ending T.
  - Lookup is combinational. Same-cycle lookup and update of the same index returns the old value.
- Counters:
  - branch_cnt increments on every conditional-branch resolve, including illegal funct3.
  - mispred_cnt increments on mispredict.
  - Both wrap from 0xFFFFFFFF to 0.
- Reset (async assert, sync-safe deassert use): state IDLE, all BHT entries 2'b01, redirect_valid=0, redirect_pc=0, flush=0, illegal_br=0, both counters 0. Reset mid-flush aborts the flush immediately.
- A correctly predicted branch produces no redirect and no flush, and the next instruction may resolve at T+1.

Decomposition:
- Shared package: funct3 encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU), FSM state enum, BHT reset value 2'b01.
- One natural sub-module, bht_2bit: counter array with comb read port and saturating update port.

Test Plan:
- BNE, rd1=5, rd2=5, ex_pred_taken=0: br_eq=1 gives not taken, no redirect, flush stays 0, branch_cnt=1, mispred_cnt=0, entry decrements 01 to 00.
- BLT, rd1=0xFFFFFFFF, rd2=1, ex_pred_taken=0, ex_pc=0x100, ex_imm=0x20:
  - br_un=0; comparator lt=1, so taken.
  - T+1: redirect_valid=1, redirect_pc=0x120.
  - flush high for 2 cycles; mispred_cnt=1.
- BLTU, same operands, ex_pred_taken=1: br_un=1; lt=0, so mispredict with redirect_pc=0x104, and the counter saturates correctly.
- JALR with ex_jalr_target=0x2003: redirect_pc=0x2002, flush 2 cycles. A branch presented during the flush is ignored and branch_cnt is unchanged.
- Same PC taken 3 times with training: if_pred_taken goes 0→1 after the 1st, and the entry saturates at 3 after the 3rd. funct3=010 pulses illegal_br and is not taken.
- Drive rst_n low during FLUSH cycle 1: flush and redirect_valid drop asynchronously, BHT returns to 01, counters read 0.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and encodings for the execute-stage branch resolver.
// Covers the conditional-branch funct3 codes, the sequencer states and the prediction-table reset value.
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] BHT_RST = 2'b01;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_resolve_ctrl_bht_2bit.sv
// Bimodal prediction table of 2-bit saturating counters.
// Combinational read port; the write port updates one entry at the clock edge.
module bht_2bit
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] r_ctr [ENTRIES];
    logic [1:0] w_cur;
    logic [1:0] w_nxt;

    // A same-cycle read of the entry being written sees the old value.
    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = r_ctr[i_wr_idx];

    always_comb begin
        w_nxt = w_cur;
        if (i_wr_taken) begin
            if (w_cur != 2'b11) w_nxt = w_cur + 2'd1;
        end else begin
            if (w_cur != 2'b00) w_nxt = w_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= BHT_RST;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_nxt;
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolver: decides taken and checks it against the prediction.
// On a mispredict or jump it issues a registered redirect and then holds the front-end flush.
//   state    | meaning
//   ST_IDLE  | accepting resolves from EX
//   ST_FLUSH | flush held, EX ignored, r_cnt cycles remaining after this one
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int BHT_IDX_W    = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_jalr_target,
    input  logic        ex_pred_taken,
    output logic        br_un,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        illegal_br,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        r_illegal;
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    logic        w_flush;
    logic        w_resolve;
    logic        w_br_resolve;
    logic        w_taken;
    logic        w_illegal_f3;
    logic        w_mispred;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [1:0]  w_pred_ctr;

    assign br_un   = ex_funct3[1];
    assign w_flush = (r_state == ST_FLUSH);

    always_comb begin
        w_taken      = 1'b0;
        w_illegal_f3 = 1'b0;
        case (ex_funct3)
            F3_BEQ:           w_taken = br_eq;
            F3_BNE:           w_taken = !br_eq;
            F3_BLT, F3_BLTU:  w_taken = br_lt;
            F3_BGE, F3_BGEU:  w_taken = !br_lt;
            default:          w_illegal_f3 = 1'b1;
        endcase
    end

    assign w_resolve    = ex_valid & !w_flush & (ex_is_branch | ex_is_jal | ex_is_jalr);
    // Jump flags outrank the branch flag when several are set.
    assign w_br_resolve = w_resolve & ex_is_branch & !ex_is_jal & !ex_is_jalr;
    assign w_mispred    = w_br_resolve & (w_taken != ex_pred_taken);
    assign w_redirect   = w_resolve & (ex_is_jalr | ex_is_jal | w_mispred);

    always_comb begin
        if (ex_is_jalr)                  w_target = {ex_jalr_target[31:1], 1'b0};
        else if (ex_is_jal || w_taken)   w_target = ex_pc + ex_imm;
        else                             w_target = ex_pc + 32'd4;
    end

    bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (if_pc[BHT_IDX_W+1:2]),
        .o_rd_ctr   (w_pred_ctr),
        .i_wr_en    (w_br_resolve),
        .i_wr_idx   (ex_pc[BHT_IDX_W+1:2]),
        .i_wr_taken (w_taken)
    );

    assign if_pred_taken = w_pred_ctr[1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_redirect) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == 3'd0) w_state_nxt = ST_IDLE;
                else               w_cnt_nxt   = r_cnt - 3'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_cnt            <= 3'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_illegal        <= 1'b0;
            r_branch_cnt     <= 32'd0;
            r_mispred_cnt    <= 32'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_redirect_valid <= w_redirect;
            if (w_redirect) r_redirect_pc <= w_target;
            r_illegal        <= w_br_resolve & w_illegal_f3;
            if (w_br_resolve) r_branch_cnt  <= r_branch_cnt + 32'd1;
            if (w_mispred)    r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign flush          = w_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign illegal_br     = r_illegal;
    assign branch_cnt     = r_branch_cnt;
    assign mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus a random run against a behavioural model.
// The bench also plays the role of the shared comparator, deriving eq/lt from its own operands.
module tb_branch_resolve_ctrl;

    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        if_pred_taken;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_pc = 32'd0, ex_imm = 32'd0, ex_jalr_target = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic        br_un;
    logic        br_eq = 1'b0, br_lt = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush, illegal_br;
    logic [31:0] branch_cnt, mispred_cnt;

    logic [31:0] op_a = 32'd0, op_b = 32'd0;

    int          n_checks = 0;
    int          n_errors = 0;

    // Behavioural model state
    int          m_bht [64];
    logic [31:0] m_branch, m_mispred, m_rpc;
    logic        m_rv, m_ill;
    int          m_flush_left;
    logic        obs_pred, exp_pred, obs_un, exp_un;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.BHT_IDX_W(6), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_jalr_target(ex_jalr_target), .ex_pred_taken(ex_pred_taken), .br_un(br_un),
        .br_eq(br_eq), .br_lt(br_lt), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .illegal_br(illegal_br),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3F);
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_branch = 0; m_mispred = 0; m_rpc = 0; m_rv = 0; m_ill = 0; m_flush_left = 0;
    endtask

    task automatic set_idle();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] a, input logic [31:0] b, input logic pred);
        ex_valid = 1; ex_is_branch = 1; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = f3; ex_pc = pc; ex_imm = imm; op_a = a; op_b = b; ex_pred_taken = pred;
    endtask

    // One clock: drive the comparator flags, record pre-edge observations, advance the model.
    task automatic run_cycle();
        logic un, tk, res, rv, ill;
        logic [31:0] tgt;
        int idx;
        un = ex_funct3[1];
        br_eq = (op_a == op_b);
        br_lt = un ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
        #1;
        obs_pred = if_pred_taken;
        exp_pred = (m_bht[pc_idx(if_pc)] >= 2);
        obs_un   = br_un;
        exp_un   = (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111) ||
                   (ex_funct3 == 3'b010) || (ex_funct3 == 3'b011);
        @(posedge clk);
        res = ex_valid && (m_flush_left == 0) && (ex_is_branch || ex_is_jal || ex_is_jalr);
        rv = 0; ill = 0; tgt = 0;
        if (res) begin
            if (ex_is_jalr) begin
                rv = 1; tgt = ex_jalr_target & 32'hFFFF_FFFE;
            end else if (ex_is_jal) begin
                rv = 1; tgt = ex_pc + ex_imm;
            end else begin
                tk = ref_taken(ex_funct3, op_a, op_b);
                m_branch = m_branch + 1;
                if (ex_funct3 == 3'b010 || ex_funct3 == 3'b011) ill = 1;
                if (tk != ex_pred_taken) begin
                    m_mispred = m_mispred + 1;
                    rv = 1;
                    tgt = tk ? ex_pc + ex_imm : ex_pc + 32'd4;
                end
                idx = pc_idx(ex_pc);
                if (tk && m_bht[idx] < 3) m_bht[idx]++;
                if (!tk && m_bht[idx] > 0) m_bht[idx]--;
            end
        end
        m_rv = rv;
        if (rv) m_rpc = tgt;
        m_ill = ill;
        if (rv) m_flush_left = FLUSH_CYCLES;
        else if (m_flush_left > 0) m_flush_left--;
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rv: got %0b expected 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'd0) begin n_errors++; $display("FAIL reset_rpc: got %0h expected 0", redirect_pc); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %0b expected 0", flush); end
        n_checks++; if (illegal_br !== 1'b0) begin n_errors++; $display("FAIL reset_ill: got %0b expected 0", illegal_br); end
        n_checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_cnt: got %0h/%0h expected 0/0", branch_cnt, mispred_cnt); end
        n_checks++; if (dut.u_bht.r_ctr[5] !== 2'b01) begin n_errors++; $display("FAIL reset_bht: got %0b expected 01", dut.u_bht.r_ctr[5]); end
        n_checks++; if (if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_pred: got %0b expected 0", if_pred_taken); end
    endtask

    task automatic test_bne();
        set_branch(3'b001, 32'h204, 32'h40, 32'd5, 32'd5, 1'b0);
        run_cycle();
        set_idle();
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL bne_rv: got %0b expected 0", redirect_valid); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL bne_flush: got %0b expected 0", flush); end
        n_checks++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd0) begin n_errors++; $display("FAIL bne_cnt: got %0d/%0d expected 1/0", branch_cnt, mispred_cnt); end
        n_checks++; if (dut.u_bht.r_ctr[1] !== 2'b00) begin n_errors++; $display("FAIL bne_bht: got %0b expected 00", dut.u_bht.r_ctr[1]); end
    endtask

    task automatic test_blt_mispredict();
        set_branch(3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_cycle();
        set_idle();
        n_checks++; if (obs_un !== 1'b0) begin n_errors++; $display("FAIL blt_un: got %0b expected 0", obs_un); end
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin n_errors++; $display("FAIL blt_redirect: got %0b/%0h expected 1/120", redirect_valid, redirect_pc); end
        n_checks++; if (flush !== 1'b1 || mispred_cnt !== 32'd1) begin n_errors++; $display("FAIL blt_flush1: got %0b/%0d expected 1/1", flush, mispred_cnt); end
        run_cycle();
        n_checks++; if (redirect_valid !== 1'b0 || flush !== 1'b1) begin n_errors++; $display("FAIL blt_flush2: got rv=%0b fl=%0b expected 0/1", redirect_valid, flush); end
        run_cycle();
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL blt_flush_end: got %0b expected 0", flush); end
    endtask

    task automatic test_bltu();
        set_branch(3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b1);
        run_cycle();
        set_idle();
        n_checks++; if (obs_un !== 1'b1) begin n_errors++; $display("FAIL bltu_un: got %0b expected 1", obs_un); end
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin n_errors++; $display("FAIL bltu_redirect: got %0b/%0h expected 1/104", redirect_valid, redirect_pc); end
        n_checks++; if (mispred_cnt !== 32'd2 || dut.u_bht.r_ctr[0] !== 2'b01) begin n_errors++; $display("FAIL bltu_train: got %0d/%0b expected 2/01", mispred_cnt, dut.u_bht.r_ctr[0]); end
        run_cycle(); run_cycle();
    endtask

    task automatic test_jalr_flush();
        ex_valid = 1; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 1; ex_jalr_target = 32'h2003;
        run_cycle();
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2002 || flush !== 1'b1) begin n_errors++; $display("FAIL jalr_redirect: got %0b/%0h/%0b expected 1/2002/1", redirect_valid, redirect_pc, flush); end
        set_branch(3'b000, 32'h300, 32'h10, 32'd7, 32'd7, 1'b0);
        run_cycle();
        set_idle();
        n_checks++; if (redirect_valid !== 1'b0 || flush !== 1'b1) begin n_errors++; $display("FAIL jalr_ignore_rv: got %0b/%0b expected 0/1", redirect_valid, flush); end
        n_checks++; if (branch_cnt !== 32'd3) begin n_errors++; $display("FAIL jalr_ignore_cnt: got %0d expected 3", branch_cnt); end
        run_cycle();
        n_checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin n_errors++; $display("FAIL jalr_flush_end: got %0b/%0b expected 0/0", flush, redirect_valid); end
    endtask

    task automatic test_training_illegal();
        if_pc = 32'h40C;
        set_branch(3'b000, 32'h40C, 32'h40, 32'd9, 32'd9, 1'b0);
        run_cycle();
        set_idle();
        n_checks++; if (obs_pred !== 1'b0 || redirect_pc !== 32'h44C) begin n_errors++; $display("FAIL train_first: got %0b/%0h expected 0/44c", obs_pred, redirect_pc); end
        run_cycle(); run_cycle();
        n_checks++; if (obs_pred !== 1'b1) begin n_errors++; $display("FAIL train_pred_up: got %0b expected 1", obs_pred); end
        set_branch(3'b000, 32'h40C, 32'h40, 32'd9, 32'd9, 1'b1);
        run_cycle();
        n_checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin n_errors++; $display("FAIL train_correct: got %0b/%0b expected 0/0", redirect_valid, flush); end
        run_cycle();
        n_checks++; if (dut.u_bht.r_ctr[3] !== 2'b11 || branch_cnt !== 32'd6) begin n_errors++; $display("FAIL train_sat: got %0b/%0d expected 11/6", dut.u_bht.r_ctr[3], branch_cnt); end
        set_branch(3'b010, 32'h510, 32'h40, 32'd1, 32'd2, 1'b0);
        run_cycle();
        set_idle();
        n_checks++; if (illegal_br !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0) begin n_errors++; $display("FAIL illegal_pulse: got %0b/%0b/%0b expected 1/0/0", illegal_br, redirect_valid, flush); end
        run_cycle();
        n_checks++; if (illegal_br !== 1'b0 || branch_cnt !== 32'd7) begin n_errors++; $display("FAIL illegal_end: got %0b/%0d expected 0/7", illegal_br, branch_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            ex_valid       = ($urandom_range(0, 9) < 8);
            ex_is_branch   = ($urandom_range(0, 9) < 7);
            ex_is_jal      = ($urandom_range(0, 9) == 0);
            ex_is_jalr     = ($urandom_range(0, 9) == 0);
            ex_funct3      = 3'($urandom_range(0, 7));
            ex_pc          = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            ex_imm         = $urandom & 32'hFFFF_FFFE;
            ex_jalr_target = $urandom;
            ex_pred_taken  = 1'($urandom_range(0, 1));
            if_pc          = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            op_a           = $urandom;
            op_b           = ($urandom_range(0, 3) == 0) ? op_a : $urandom;
            run_cycle();
            n_checks++; if (obs_pred !== exp_pred) begin n_errors++; $display("FAIL rnd_pred[%0d]: got %0b expected %0b", n, obs_pred, exp_pred); end
            n_checks++; if (obs_un !== exp_un) begin n_errors++; $display("FAIL rnd_un[%0d]: got %0b expected %0b", n, obs_un, exp_un); end
            n_checks++; if (redirect_valid !== m_rv) begin n_errors++; $display("FAIL rnd_rv[%0d]: got %0b expected %0b", n, redirect_valid, m_rv); end
            n_checks++; if (redirect_pc !== m_rpc) begin n_errors++; $display("FAIL rnd_rpc[%0d]: got %0h expected %0h", n, redirect_pc, m_rpc); end
            n_checks++; if (flush !== (m_flush_left > 0)) begin n_errors++; $display("FAIL rnd_flush[%0d]: got %0b expected %0b", n, flush, m_flush_left > 0); end
            n_checks++; if (illegal_br !== m_ill) begin n_errors++; $display("FAIL rnd_ill[%0d]: got %0b expected %0b", n, illegal_br, m_ill); end
            n_checks++; if (branch_cnt !== m_branch) begin n_errors++; $display("FAIL rnd_bcnt[%0d]: got %0d expected %0d", n, branch_cnt, m_branch); end
            n_checks++; if (mispred_cnt !== m_mispred) begin n_errors++; $display("FAIL rnd_mcnt[%0d]: got %0d expected %0d", n, mispred_cnt, m_mispred); end
        end
        set_idle();
        for (int n = 0; n < 4; n++) run_cycle();
    endtask

    task automatic test_reset_mid_flush();
        ex_valid = 1; ex_is_branch = 0; ex_is_jal = 1; ex_is_jalr = 0;
        ex_pc = 32'h600; ex_imm = 32'h8; if_pc = 32'h40C;
        run_cycle();
        set_idle();
        n_checks++; if (flush !== 1'b1 || redirect_pc !== 32'h608) begin n_errors++; $display("FAIL rst_setup: got %0b/%0h expected 1/608", flush, redirect_pc); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin n_errors++; $display("FAIL rst_abort: got %0b/%0b expected 0/0", flush, redirect_valid); end
        n_checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", branch_cnt, mispred_cnt); end
        n_checks++; if (dut.u_bht.r_ctr[3] !== 2'b01 || if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL rst_bht: got %0b/%0b expected 01/0", dut.u_bht.r_ctr[3], if_pred_taken); end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_bne();
        test_blt_mispredict();
        test_bltu();
        test_jalr_flush();
        test_training_illegal();
        test_random();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
